aug_pipeline_scheduler: RTL and testbench

- Batch-level controller for the augmentation datapath: input buffer BRAM -> blur BRAM -> rotation BRAM -> intermediate-results BRAM.
- Sequences kernel load, then per image three stage engines: LOAD (input copy), BLUR, ROT.
- Uses ping-pong halves of the blur and rotation BRAMs so that up to three images are in flight.
- Sits between the PS GPIO controls (start, read_kernel) and the stage engines, and supplies all base addresses.

---
 rtl/aug_sched_pkg.sv | 12 +
 rtl/aug_stage_tracker.sv | 40 ++++
 rtl/aug_pipeline_scheduler.sv | 156 +++++++++++++++
 tb/tb_aug_pipeline_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aug_sched_pkg.sv
// aug_sched_pkg: shared types and helpers for the augmentation pipeline scheduler.
package aug_sched_pkg;
  typedef enum logic [1:0] {IDLE, KERNEL, RUN, DONE} state_t;
  localparam int MAX_IMAGES = 255;
  localparam int IDX_W = $clog2(MAX_IMAGES + 1);
  function automatic logic [15:0] half_base(input logic lsb, input logic [15:0] b1, input logic [15:0] b2);
    return lsb ? b2 : b1;
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return &x ? x : x + 32'd1;
  endfunction
endpackage

// File: rtl/aug_stage_tracker.sv
// aug_stage_tracker: busy flag, issue/done counters, start pulse and err for one stage engine.
module aug_stage_tracker import aug_sched_pkg::*; #(
  parameter int NUM_IMAGES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_run,
  input  logic             i_clr,
  input  logic             i_can,
  input  logic             i_done,
  output logic             o_fire,
  output logic             o_start,
  output logic             o_err,
  output logic [IDX_W-1:0] o_iss,
  output logic [IDX_W-1:0] o_cnt
);
  logic r_busy, r_start, r_err;
  logic [IDX_W-1:0] r_iss, r_cnt;
  // A done in this cycle frees the engine, so the next image can start on the following cycle.
  assign o_fire  = i_run & (~r_busy | i_done) & i_can & (r_iss < IDX_W'(NUM_IMAGES));
  assign o_start = r_start;
  assign o_err   = r_err;
  assign o_iss   = r_iss;
  assign o_cnt   = r_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
      r_iss   <= '0;
      r_cnt   <= '0;
    end else begin
      r_start <= o_fire;
      r_busy  <= o_fire | (r_busy & ~i_done);
      r_err   <= r_err | (i_done & ~r_busy);
      r_iss   <= i_clr ? '0 : r_iss + IDX_W'(o_fire);
      r_cnt   <= i_clr ? '0 : r_cnt + IDX_W'(i_done & r_busy);
    end
  end
endmodule

// File: rtl/aug_pipeline_scheduler.sv
// aug_pipeline_scheduler: batch controller for kernel load and LOAD/BLUR/ROT with ping-pong halves.
// Optional perf counters enabled by defining AUG_SCHED_PERF_EN.
module aug_pipeline_scheduler import aug_sched_pkg::*; #(
  parameter int                      NUM_IMAGES      = 8,
  parameter int                      NUM_PIXELS      = 784,
  parameter int                      ADDR_WIDTH_PS   = 32,
  parameter int                      ADDR_WIDTH_INT  = 11,
  parameter logic [ADDR_WIDTH_INT-1:0] BRAM_INT_BASE1 = 11'h000,
  parameter logic [ADDR_WIDTH_INT-1:0] BRAM_INT_BASE2 = 11'h310,
  parameter logic [ADDR_WIDTH_PS-1:0]  IMAGE_BASE_ADDR = 32'h0000_0024,
  parameter logic [ADDR_WIDTH_PS-1:0]  OUT_BASE_ADDR   = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      read_kernel,
  output logic                      kernel_start,
  input  logic                      kernel_done,
  output logic                      load_start,
  output logic [ADDR_WIDTH_PS-1:0]  load_src_addr,
  output logic [ADDR_WIDTH_INT-1:0] load_dst_base,
  input  logic                      load_done,
  output logic                      blur_start,
  output logic [ADDR_WIDTH_INT-1:0] blur_src_base,
  output logic [ADDR_WIDTH_INT-1:0] blur_dst_base,
  input  logic                      blur_done,
  output logic                      rot_start,
  output logic [ADDR_WIDTH_INT-1:0] rot_src_base,
  output logic [ADDR_WIDTH_PS-1:0]  rot_dst_addr,
  input  logic                      rot_done,
  output logic                      busy,
  output logic                      batch_done,
  output logic                      err
`ifdef AUG_SCHED_PERF_EN
  ,
  output logic [31:0]               perf_cycles,
  output logic [31:0]               perf_blur_stall
`endif
);
  localparam logic [15:0] B1 = 16'(BRAM_INT_BASE1);
  localparam logic [15:0] B2 = 16'(BRAM_INT_BASE2);
  state_t r_state;
  logic r_start_q, r_rk_q, r_kvalid, r_pend, r_err_k;
  logic [ADDR_WIDTH_PS-1:0] r_ld_off, r_rt_off;
  logic w_st_edge, w_rk_edge, w_run, w_clr, w_done_now;
  logic w_ld_fire, w_bl_fire, w_rt_fire, w_ld_can, w_bl_can, w_rt_can;
  logic w_ld_err, w_bl_err, w_rt_err;
  logic [IDX_W-1:0] w_ld_iss, w_ld_cnt, w_bl_iss, w_bl_cnt, w_rt_iss, w_rt_cnt;
  logic [ADDR_WIDTH_INT-1:0] w_ld_half, w_bl_half, w_rt_half;
  assign w_st_edge  = start & ~r_start_q;
  assign w_rk_edge  = read_kernel & ~r_rk_q;
  assign w_run      = r_state == RUN;
  assign w_clr      = r_state == DONE;
  assign w_done_now = w_run & (w_rt_cnt == IDX_W'(NUM_IMAGES));
  // A target half is free once the image two slots back has left it.
  assign w_ld_can   = {1'b0, w_ld_iss} < {1'b0, w_bl_cnt} + (IDX_W + 1)'(2);
  assign w_bl_can   = (w_bl_iss < w_ld_cnt) & ({1'b0, w_bl_iss} < {1'b0, w_rt_cnt} + (IDX_W + 1)'(2));
  assign w_rt_can   = w_rt_iss < w_bl_cnt;
  assign w_ld_half  = ADDR_WIDTH_INT'(half_base(w_ld_iss[0], B1, B2));
  assign w_bl_half  = ADDR_WIDTH_INT'(half_base(w_bl_iss[0], B1, B2));
  assign w_rt_half  = ADDR_WIDTH_INT'(half_base(w_rt_iss[0], B1, B2));
  assign busy       = r_state != IDLE;
  assign err        = r_err_k | w_ld_err | w_bl_err | w_rt_err;
  aug_stage_tracker #(.NUM_IMAGES(NUM_IMAGES)) u_ld (
    .clk(clk), .reset(reset), .i_run(w_run), .i_clr(w_clr), .i_can(w_ld_can), .i_done(load_done),
    .o_fire(w_ld_fire), .o_start(load_start), .o_err(w_ld_err), .o_iss(w_ld_iss), .o_cnt(w_ld_cnt));
  aug_stage_tracker #(.NUM_IMAGES(NUM_IMAGES)) u_bl (
    .clk(clk), .reset(reset), .i_run(w_run), .i_clr(w_clr), .i_can(w_bl_can), .i_done(blur_done),
    .o_fire(w_bl_fire), .o_start(blur_start), .o_err(w_bl_err), .o_iss(w_bl_iss), .o_cnt(w_bl_cnt));
  aug_stage_tracker #(.NUM_IMAGES(NUM_IMAGES)) u_rt (
    .clk(clk), .reset(reset), .i_run(w_run), .i_clr(w_clr), .i_can(w_rt_can), .i_done(rot_done),
    .o_fire(w_rt_fire), .o_start(rot_start), .o_err(w_rt_err), .o_iss(w_rt_iss), .o_cnt(w_rt_cnt));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_start_q     <= 1'b0;
      r_rk_q        <= 1'b0;
      r_kvalid      <= 1'b0;
      r_pend        <= 1'b0;
      r_err_k       <= 1'b0;
      r_ld_off      <= '0;
      r_rt_off      <= '0;
      kernel_start  <= 1'b0;
      batch_done    <= 1'b0;
      load_src_addr <= '0;
      load_dst_base <= '0;
      blur_src_base <= '0;
      blur_dst_base <= '0;
      rot_src_base  <= '0;
      rot_dst_addr  <= '0;
    end else begin
      r_start_q    <= start;
      r_rk_q       <= read_kernel;
      kernel_start <= 1'b0;
      batch_done   <= 1'b0;
      r_err_k      <= r_err_k | (kernel_done & (r_state != KERNEL));
      if (w_ld_fire) begin
        load_src_addr <= IMAGE_BASE_ADDR + r_ld_off;
        r_ld_off      <= r_ld_off + ADDR_WIDTH_PS'(NUM_PIXELS);
        load_dst_base <= w_ld_half;
      end
      if (w_bl_fire) begin
        blur_src_base <= w_bl_half;
        blur_dst_base <= w_bl_half;
      end
      if (w_rt_fire) begin
        rot_src_base <= w_rt_half;
        rot_dst_addr <= OUT_BASE_ADDR + r_rt_off;
        r_rt_off     <= r_rt_off + ADDR_WIDTH_PS'(NUM_PIXELS);
      end
      case (r_state)
        IDLE: if (w_rk_edge | w_st_edge) begin
          r_state      <= (w_rk_edge | ~r_kvalid) ? KERNEL : RUN;
          kernel_start <= w_rk_edge | ~r_kvalid;
          r_pend       <= w_st_edge;
        end
        KERNEL: if (kernel_done) begin
          r_kvalid <= 1'b1;
          r_state  <= r_pend ? RUN : IDLE;
        end
        RUN: if (w_done_now) begin
          r_state    <= DONE;
          batch_done <= 1'b1;
        end
        DONE: begin
          r_state  <= IDLE;
          r_ld_off <= '0;
          r_rt_off <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef AUG_SCHED_PERF_EN
  logic [31:0] r_pc, r_bs;
  logic w_stall;
  // Blur is idle exactly when every issued image has completed.
  assign w_stall = w_run & (w_bl_iss == w_bl_cnt) & ~w_bl_fire;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc            <= '0;
      r_bs            <= '0;
      perf_cycles     <= '0;
      perf_blur_stall <= '0;
    end else if (w_done_now) begin
      perf_cycles     <= sat_inc(r_pc);
      perf_blur_stall <= w_stall ? sat_inc(r_bs) : r_bs;
      r_pc            <= '0;
      r_bs            <= '0;
    end else if (w_run) begin
      r_pc <= sat_inc(r_pc);
      r_bs <= w_stall ? sat_inc(r_bs) : r_bs;
    end
  end
`endif
endmodule

// File: tb/tb_aug_pipeline_scheduler.sv
// tb_aug_pipeline_scheduler: directed bench with latency-modelled engines and per-image vector table.
module tb_aug_pipeline_scheduler;
  typedef struct {
    logic [31:0] src;
    logic [10:0] half;
    logic [31:0] dst;
  } vec_t;
  logic clk = 0, reset = 1, start = 0, read_kernel = 0, spur = 0;
  logic kernel_start, kernel_done, load_start, load_done, blur_start, blur_done;
  logic rot_start, rot_done, rot_done_m, busy, batch_done, err;
  logic [31:0] load_src_addr, rot_dst_addr;
  logic [10:0] load_dst_base, blur_src_base, blur_dst_base, rot_src_base;
  int checks = 0, errors = 0, cyc = 0;
  int ld_lat = 10, bl_lat = 20, rt_lat = 15, kd_lat = 5;
  int kcd = 0, lcd = 0, bcd = 0, rcd = 0;
  int ks_n = 0, kd_n = 0, kd_t0 = -1, ls_n = 0, ls_t0 = -1;
  int bs_n = 0, bd_n = 0, rs_n = 0, rd_n = 0, bat_n = 0;
  int bl_i = 0, bd_c = 0, rt_c = 0, viol = 0, maxdiff = 0;
  logic track = 0;
  logic [31:0] ls_src[64], rs_dst[64];
  logic [10:0] ls_dst[64], bs_src[64], bs_dst[64], rs_src[64];
  int bs_t[64], bd_t[64];
  vec_t tbl[8];

  assign rot_done = rot_done_m | spur;

  aug_pipeline_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .read_kernel(read_kernel),
    .kernel_start(kernel_start), .kernel_done(kernel_done),
    .load_start(load_start), .load_src_addr(load_src_addr), .load_dst_base(load_dst_base), .load_done(load_done),
    .blur_start(blur_start), .blur_src_base(blur_src_base), .blur_dst_base(blur_dst_base), .blur_done(blur_done),
    .rot_start(rot_start), .rot_src_base(rot_src_base), .rot_dst_addr(rot_dst_addr), .rot_done(rot_done),
    .busy(busy), .batch_done(batch_done), .err(err));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (track && (bd_c - rt_c) > maxdiff) maxdiff = bd_c - rt_c;
  end

  always @(negedge clk) if (batch_done) bat_n++;

  always @(negedge clk) begin
    kernel_done = 0;
    if (reset) kcd = 0;
    else begin
      if (kcd > 0) begin
        kcd--;
        if (kcd == 0) begin
          kernel_done = 1;
          if (kd_n == 0) kd_t0 = cyc;
          kd_n++;
        end
      end
      if (kernel_start) begin
        ks_n++;
        kcd = kd_lat;
      end
    end
  end

  always @(negedge clk) begin
    load_done = 0;
    if (reset) lcd = 0;
    else begin
      if (lcd > 0) begin
        lcd--;
        if (lcd == 0) load_done = 1;
      end
      if (load_start) begin
        if (ls_n == 0) ls_t0 = cyc;
        if (ls_n < 64) begin
          ls_src[ls_n] = load_src_addr;
          ls_dst[ls_n] = load_dst_base;
        end
        ls_n++;
        lcd = ld_lat;
      end
    end
  end

  always @(negedge clk) begin
    blur_done = 0;
    if (reset) bcd = 0;
    if (reset || batch_done) begin
      bl_i = 0;
      bd_c = 0;
    end else begin
      if (bcd > 0) begin
        bcd--;
        if (bcd == 0) begin
          blur_done = 1;
          if (bd_n < 64) bd_t[bd_n] = cyc;
          bd_n++;
          bd_c++;
        end
      end
      if (blur_start) begin
        if (bl_i >= rt_c + 2) viol++;
        bl_i++;
        if (bs_n < 64) begin
          bs_t[bs_n] = cyc;
          bs_src[bs_n] = blur_src_base;
          bs_dst[bs_n] = blur_dst_base;
        end
        bs_n++;
        bcd = bl_lat;
      end
    end
  end

  always @(negedge clk) begin
    rot_done_m = 0;
    if (reset) rcd = 0;
    if (reset || batch_done) rt_c = 0;
    else begin
      if (rcd > 0) begin
        rcd--;
        if (rcd == 0) begin
          rot_done_m = 1;
          rd_n++;
          rt_c++;
        end
      end
      if (rot_start) begin
        if (rs_n < 64) begin
          rs_src[rs_n] = rot_src_base;
          rs_dst[rs_n] = rot_dst_addr;
        end
        rs_n++;
        rcd = rt_lat;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_batch(input int maxc);
    int b0;
    int n;
    b0 = bat_n;
    n = 0;
    while (bat_n == b0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    chk("batch_done_count", 32'(bat_n - b0), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    repeat (2) @(negedge clk);
    start = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_starts"}, 32'({kernel_start, load_start, blur_start, rot_start, batch_done}), 32'd0);
    chk({tag, "_load_src"}, load_src_addr, 32'd0);
    chk({tag, "_rot_dst"}, rot_dst_addr, 32'd0);
    chk({tag, "_bases"}, 32'({load_dst_base, blur_src_base} | {blur_dst_base, rot_src_base}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int k0, b0, l0, n;
    tbl[0] = '{32'h0024, 11'h000, 32'h0000};
    tbl[1] = '{32'h0334, 11'h310, 32'h0310};
    tbl[2] = '{32'h0644, 11'h000, 32'h0620};
    tbl[3] = '{32'h0954, 11'h310, 32'h0930};
    tbl[4] = '{32'h0C64, 11'h000, 32'h0C40};
    tbl[5] = '{32'h0F74, 11'h310, 32'h0F50};
    tbl[6] = '{32'h1284, 11'h000, 32'h1260};
    tbl[7] = '{32'h1594, 11'h310, 32'h1570};

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk) reset = 0;

    // Fresh batch: kernel load is triggered first, then the eight images.
    pulse_start();
    wait_batch(3000);
    chk("kernel_start_count", 32'(ks_n), 32'd1);
    chk("load_after_kernel_done", 32'(ls_t0 > kd_t0), 32'd1);
    chk("rot_done_count", 32'(rd_n), 32'd8);
    chk("load_count", 32'(ls_n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("load_src_%0d", i), ls_src[i], tbl[i].src);
      chk($sformatf("load_dst_%0d", i), 32'(ls_dst[i]), 32'(tbl[i].half));
      chk($sformatf("blur_src_%0d", i), 32'(bs_src[i]), 32'(tbl[i].half));
      chk($sformatf("blur_dst_%0d", i), 32'(bs_dst[i]), 32'(tbl[i].half));
      chk($sformatf("rot_src_%0d", i), 32'(rs_src[i]), 32'(tbl[i].half));
      chk($sformatf("rot_dst_%0d", i), rs_dst[i], tbl[i].dst);
    end
    for (int i = 0; i < 7; i++)
      chk($sformatf("blur_b2b_%0d", i), 32'(bs_t[i + 1] - bd_t[i]), 32'd1);

    // Stalled ROT: blur may run at most two images ahead.
    rt_lat = 200;
    track = 1;
    pulse_start();
    wait_batch(5000);
    track = 0;
    rt_lat = 15;
    chk("stall_max_ahead", 32'(maxdiff), 32'd2);
    chk("stall_no_reload", 32'(ks_n), 32'd1);

    // Reset during image 3 blur aborts everything and forgets the kernel.
    b0 = bs_n;
    pulse_start();
    n = 0;
    while (bs_n < b0 + 4 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("reached_blur3", 32'(bs_n >= b0 + 4), 32'd1);
    #1;
    chk("busy_mid_batch", 32'(busy), 32'd1);
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    reset = 0;
    k0 = ks_n;
    pulse_start();
    n = 0;
    while (ks_n == k0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("kernel_reload", 32'(ks_n - k0), 32'd1);
    wait_batch(3000);
    chk("err_clean_batch", 32'(err), 32'd0);

    // Spurious rot_done in IDLE sets a sticky err.
    @(negedge clk) spur = 1;
    @(negedge clk) spur = 0;
    @(posedge clk);
    #1;
    chk("err_set", 32'(err), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", 32'(err), 32'd1);

    // Start held across batch_done must not retrigger.
    @(negedge clk) start = 1;
    wait_batch(3000);
    chk("err_after_batch", 32'(err), 32'd1);
    l0 = ls_n;
    repeat (30) @(posedge clk);
    #1;
    chk("held_start_idle", 32'(busy), 32'd0);
    chk("held_start_no_load", 32'(ls_n - l0), 32'd0);
    @(negedge clk) start = 0;
    repeat (2) @(negedge clk);
    start = 1;
    wait_batch(3000);
    start = 0;
    chk("relaunch_loads", 32'(ls_n - l0), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
